countdown_seconds_timer: RTL and testbench
==========================================

// Module: countdown_seconds_timer
// PURPOSE
//  Game countdown stage that consumes the 1 Hz single-cycle pulse from the one-second timer.
//  Holds a 2-digit BCD seconds count and gates that timer through timerEnable.
//  Flags the last seconds and signals time-up to the game-control FSM.
//  Sits between the one-second timer and the game FSM / 7-segment display decoders.
// PARAMETERS
//  START_SECS  60  load value in seconds, legal 0..99
//  WARN_SECS   10  warning asserted when count <= WARN_SECS and count != 0; legal 0..START_SECS
// PORTS
//  clk            in   1  system clock, 50 MHz
//  rst            in   1  synchronous, active-high reset
//  load           in   1  pulse: reload START_SECS, go to IDLE
//  start          in   1  pulse: begin or resume countdown
//  pause          in   1  pulse: freeze countdown
//  oneSecTimeout  in   1  single-cycle 1 Hz tick from the one-second timer
//  timerEnable    out  1  enable to the one-second timer; high only in RUN
//  secTens        out  4  BCD tens digit of the remaining seconds
//  secOnes        out  4  BCD ones digit of the remaining seconds
//  warning        out  1  level: low-time warning
//  timeUp         out  1  single-cycle pulse when the count reaches 00
//  expired        out  1  level: high while in EXPIRED
// BEHAVIOUR
//  - All state updates happen on the rising edge of clk. Reset is synchronous and active-high.
//  - Reset values:
//    - state = IDLE
//    - {secTens, secOnes} = BCD(START_SECS)
//    - timerEnable = 0, warning = 0, timeUp = 0, expired = 0
//  - States: IDLE, RUN, PAUSED, EXPIRED. Encoding is free.
//  - Input priority, per cycle: rst > load > pause > start > oneSecTimeout.
//  - load, in any state:
//    - reload the count to BCD(START_SECS), go to IDLE
//    - any other input in the same cycle is ignored
//  - IDLE:
//    - start with count != 0 -> RUN
//    - start with count == 0 -> EXPIRED, with timeUp pulsed on the same edge
//  - RUN:
//    - pause -> PAUSED; a tick in the same cycle is dropped
//    - tick with count > 1 -> BCD decrement
//    - tick with count == 1 -> count 00, go to EXPIRED, timeUp pulsed
//  - PAUSED:
//    - start -> RUN
//    - ticks are ignored; the count holds
//  - EXPIRED:
//    - holds 00 until load
//    - start, pause and ticks are ignored
//  - BCD decrement:
//    - if ones != 0: ones - 1
//    - else: ones = 9 and tens - 1
//    - digits never leave 0..9
//    - no wrap below 00 in any state
//  - Latency: a tick sampled high at edge N gives the new digits visible after edge N.
//    Exactly one decrement per tick.
//  - timerEnable = (state == RUN), decoded from the registered state, so it is glitch-free.
//    The upstream timer is therefore stopped in IDLE, PAUSED and EXPIRED.
//  - warning = (state is RUN or PAUSED) and 1 <= count <= WARN_SECS, combinational from registers.
//  - timeUp is registered: high for exactly one cycle, on the cycle after the edge that enters EXPIRED.
//  - expired is high for every cycle spent in EXPIRED.
//  - Reset asserted in mid-countdown: the next edge restores the reset values; a pending tick is discarded.
// TESTING
//  1. rst for 2 cycles, START_SECS=60
//     -> secTens=6, secOnes=0, timerEnable=0, timeUp=0, expired=0
//  2. load, start, then one tick
//     -> count 59; timerEnable=1 from the cycle after start
//  3. With count 10, tick
//     -> count 09; warning stays 1 (WARN_SECS=10)
//  4. pause in RUN at 45, then 3 ticks, then start
//     -> count holds 45, timerEnable=0 while paused; the next tick after start gives 44
//  5. At count 01, tick
//     -> 00, expired=1, timeUp high exactly 1 cycle
//     -> further ticks and start leave 00; load returns to 60 and IDLE
//  6. pause and tick in the same cycle at 30 -> 30 held, PAUSED
//     load and start in the same cycle -> IDLE at 60
//     START_SECS=0 build, start -> immediate timeUp

Source files
------------

// File: rtl/countdown_seconds_timer.sv
// countdown_seconds_timer: BCD seconds countdown gated by a 1 Hz tick, with warning and time-up flags
module countdown_seconds_timer #(
  parameter int START_SECS = 60,
  parameter int WARN_SECS  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic       oneSecTimeout,
  output logic       timerEnable,
  output logic [3:0] secTens,
  output logic [3:0] secOnes,
  output logic       warning,
  output logic       timeUp,
  output logic       expired
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;
  localparam logic [3:0] START_TENS = 4'(START_SECS / 10);
  localparam logic [3:0] START_ONES = 4'(START_SECS % 10);
  state_t     state, state_n;
  logic [3:0] tens_n, ones_n;
  logic       time_up_n, is_zero, is_one;
  logic [6:0] count;
  assign is_zero     = secTens == 4'd0 && secOnes == 4'd0;
  assign is_one      = secTens == 4'd0 && secOnes == 4'd1;
  assign count       = 7'(secTens) * 7'd10 + 7'(secOnes);
  assign timerEnable = state == RUN;
  assign expired     = state == EXPIRED;
  assign warning     = (state == RUN || state == PAUSED) && !is_zero && count <= 7'(WARN_SECS);
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      secTens <= START_TENS;
      secOnes <= START_ONES;
      timeUp  <= 1'b0;
    end else begin
      state   <= state_n;
      secTens <= tens_n;
      secOnes <= ones_n;
      timeUp  <= time_up_n;
    end
  end
  // pause outranks start in every state, so a simultaneous pair never starts the count
  always_comb begin
    state_n   = state;
    tens_n    = secTens;
    ones_n    = secOnes;
    time_up_n = 1'b0;
    if (load) begin
      state_n = IDLE;
      tens_n  = START_TENS;
      ones_n  = START_ONES;
    end else begin
      case (state)
        IDLE: begin
          if (start && !pause) begin
            state_n   = is_zero ? EXPIRED : RUN;
            time_up_n = is_zero;
          end
        end
        RUN: begin
          if (pause) begin
            state_n = PAUSED;
          end else if (oneSecTimeout && is_one) begin
            state_n   = EXPIRED;
            tens_n    = 4'd0;
            ones_n    = 4'd0;
            time_up_n = 1'b1;
          end else if (oneSecTimeout && !is_zero) begin
            ones_n = secOnes != 4'd0 ? secOnes - 4'd1 : 4'd9;
            tens_n = secOnes != 4'd0 ? secTens : secTens - 4'd1;
          end
        end
        PAUSED:  state_n = start && !pause ? RUN : PAUSED;
        EXPIRED: state_n = EXPIRED;
      endcase
    end
  end
endmodule

// File: tb/tb_countdown_seconds_timer.sv
// tb_countdown_seconds_timer: directed stimulus, per-cycle comparison against an integer-count model
module tb_countdown_seconds_timer;
  logic clk = 1'b0, rst = 1'b1, load = 1'b0, start = 1'b0, pause = 1'b0, tick = 1'b0;
  logic       en, warn, tu, exp_o;
  logic [3:0] tens, ones;
  logic       z_en, z_warn, z_tu, z_exp;
  logic [3:0] z_tens, z_ones;
  int n_chk = 0, n_fail = 0;
  bit chk_on = 1'b0;
  always #5 clk = ~clk;

  countdown_seconds_timer #(.START_SECS(60), .WARN_SECS(10)) dut (
    .clk(clk), .rst(rst), .load(load), .start(start), .pause(pause), .oneSecTimeout(tick),
    .timerEnable(en), .secTens(tens), .secOnes(ones), .warning(warn), .timeUp(tu), .expired(exp_o));

  countdown_seconds_timer #(.START_SECS(0), .WARN_SECS(0)) dut_zero (
    .clk(clk), .rst(rst), .load(load), .start(start), .pause(pause), .oneSecTimeout(tick),
    .timerEnable(z_en), .secTens(z_tens), .secOnes(z_ones), .warning(z_warn), .timeUp(z_tu), .expired(z_exp));

  // model: plain integer seconds plus a mode name
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;
  int m_cnt = 60, m_mode = M_IDLE;
  bit m_tu = 1'b0;
  always @(posedge clk) begin
    m_tu = 1'b0;
    if (rst || load) begin
      m_cnt  = 60;
      m_mode = M_IDLE;
    end else if (pause) begin
      if (m_mode == M_RUN) m_mode = M_PAUSE;
    end else if (start && (m_mode == M_IDLE || m_mode == M_PAUSE)) begin
      if (m_cnt == 0) begin
        m_mode = M_EXP;
        m_tu   = 1'b1;
      end else m_mode = M_RUN;
    end else if (tick && m_mode == M_RUN && m_cnt > 0) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_mode = M_EXP;
        m_tu   = 1'b1;
      end
    end
  end

  task automatic check(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("tens", int'(tens), m_cnt / 10);
      check("ones", int'(ones), m_cnt % 10);
      check("timerEnable", int'(en), int'(m_mode == M_RUN));
      check("expired", int'(exp_o), int'(m_mode == M_EXP));
      check("timeUp", int'(tu), int'(m_tu));
      check("warning", int'(warn), int'((m_mode == M_RUN || m_mode == M_PAUSE) && m_cnt >= 1 && m_cnt <= 10));
    end
  end

  // one cycle of inputs; returns just after the edge that sampled them
  task automatic cyc(input bit r, input bit l, input bit s, input bit p, input bit t);
    rst = r; load = l; start = s; pause = p; tick = t;
    @(posedge clk);
    #2;
    rst = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(0, 0, 0, 0, 1);
      if (i % 3 == 0) cyc(0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    chk_on = 1'b1;
    check("rst_tens", int'(tens), 6);
    check("rst_ones", int'(ones), 0);
    check("rst_en", int'(en), 0);
    check("rst_tu", int'(tu), 0);
    check("rst_exp", int'(exp_o), 0);
    check("zero_rst_exp", int'(z_exp), 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    check("zero_start_tu", int'(z_tu), 1);
    check("zero_start_exp", int'(z_exp), 1);
    check("zero_start_cnt", int'({z_tens, z_ones}), 0);
    check("zero_start_en", int'(z_en), 0);
    check("en_after_start", int'(en), 1);
    cyc(0, 0, 0, 0, 0);
    check("zero_tu_one_cycle", int'(z_tu), 0);
    cyc(0, 0, 0, 0, 1);
    check("first_tick", int'({tens, ones}), 8'h59);
    ticks(14);
    check("at_45", int'({tens, ones}), 8'h45);
    cyc(0, 0, 0, 1, 0);
    check("paused_en", int'(en), 0);
    ticks(3);
    check("paused_hold", int'({tens, ones}), 8'h45);
    cyc(0, 0, 1, 0, 0);
    check("resume_en", int'(en), 1);
    cyc(0, 0, 0, 0, 1);
    check("resume_tick", int'({tens, ones}), 8'h44);
    ticks(14);
    cyc(0, 0, 0, 1, 1);
    check("pause_tick_cnt", int'({tens, ones}), 8'h30);
    check("pause_tick_en", int'(en), 0);
    cyc(0, 0, 1, 0, 0);
    ticks(19);
    check("warn_at_11", int'(warn), 0);
    cyc(0, 0, 0, 0, 1);
    check("warn_at_10", int'(warn), 1);
    cyc(0, 0, 0, 0, 1);
    check("borrow_09", int'({tens, ones}), 8'h09);
    check("warn_at_09", int'(warn), 1);
    ticks(8);
    check("at_01", int'({tens, ones}), 8'h01);
    cyc(0, 0, 0, 0, 1);
    check("expire_cnt", int'({tens, ones}), 0);
    check("expire_tu", int'(tu), 1);
    check("expire_flag", int'(exp_o), 1);
    check("expire_warn", int'(warn), 0);
    cyc(0, 0, 0, 0, 0);
    check("tu_drop", int'(tu), 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1);
    check("expired_hold", int'({tens, ones}), 0);
    check("expired_still", int'(exp_o), 1);
    cyc(0, 1, 0, 0, 0);
    check("reload_cnt", int'({tens, ones}), 8'h60);
    check("reload_exp", int'(exp_o), 0);
    cyc(0, 1, 1, 0, 0);
    check("load_start_en", int'(en), 0);
    cyc(0, 0, 1, 1, 0);
    check("start_pause_idle", int'(en), 0);
    cyc(0, 0, 1, 0, 0);
    ticks(3);
    check("run_57", int'({tens, ones}), 8'h57);
    cyc(1, 0, 0, 0, 1);
    check("midrst_cnt", int'({tens, ones}), 8'h60);
    check("midrst_en", int'(en), 0);
    repeat (3) cyc(0, 0, 0, 0, 1);
    check("idle_ignores_tick", int'({tens, ones}), 8'h60);
    @(posedge clk);
    #7;
    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
